mux2_arb: RTL and testbench
===========================

MUX2_ARB -- requirements
Module: mux2_arb

Interface
REQ-001 Parameter: WIDTH, default 1, data width of each channel.
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: d0  input  WIDTH  channel-0 data.
REQ-005 Port: v0  input  1  channel-0 valid.
REQ-006 Port: r0  output  1  channel-0 ready; transfer when v0&&r0.
REQ-007 Port: d1  input  WIDTH  channel-1 data.
REQ-008 Port: v1  input  1  channel-1 valid.
REQ-009 Port: r1  output  1  channel-1 ready; transfer when v1&&r1.
REQ-010 Port: z  output  WIDTH  registered output data.
REQ-011 Port: zv  output  1  output valid.
REQ-012 Port: zr  input  1  output ready; transfer when zv&&zr.
REQ-013 Port: sel  output  1  source channel of the item held in z (0=d0, 1=d1).

Function
REQ-014 The block SHALL arbitrate channels 0 and 1 onto a single registered output stage through a 2:1 data select.
REQ-015 FSM states: EMPTY (zv=0) and FULL (zv=1); zv SHALL equal (state==FULL).
REQ-016 Accept condition: acc = (state==EMPTY) || zr.
REQ-017 Grant, combinational: only v0 -> g=0; only v1 -> g=1; both -> g=~last; neither -> no grant.
REQ-018 r0 SHALL be acc && v0 && g==0; r1 SHALL be acc && v1 && g==1; at most one of r0, r1 is high in any cycle.
REQ-019 On a transfer of channel g: z<=d_g, sel<=g, last<=g, state<=FULL, all at the next edge (latency 1 cycle).
REQ-020 FULL with zr=1 and no input transfer: state<=EMPTY; z and sel unchanged.
REQ-021 FULL with zr=1 and an input transfer: output drains and reloads in the same edge; throughput 1 item/cycle.
REQ-022 FULL with zr=0: z, sel and zv SHALL hold stable; r0=r1=0.
REQ-023 last SHALL update only on an input transfer, never on an output transfer or an idle cycle.
REQ-024 Neither valid: no state change other than REQ-020.
REQ-025 Items SHALL never be duplicated or dropped except by reset.

Reset
REQ-026 rst_n low SHALL asynchronously force state=EMPTY, zv=0, z=0, sel=0, last=1, so channel 0 wins the first tie.
REQ-027 Assertion mid-transfer SHALL discard the held item; r0=r1=0 only while rst_n is low.
REQ-028 First grant possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 Package mux2_arb_pkg SHALL hold the state enum {EMPTY, FULL} and the default-width constant.
REQ-030 Data select SHALL reuse existing module mux2 (d0, d1, sel, z), one instance per data bit, driven by g; no other sub-modules.
REQ-031 Target size 120-400 lines RTL; no latches; one always_ff for state/z/sel/last, combinational grant/ready.

Verification
REQ-032 Reset release, v0=1 d0=1, v1=0, zr=1 -> r0=1 at cycle 0; zv=1, z=1, sel=0 at cycle 1.
REQ-033 v0=v1=1 held, d0=0, d1=1, zr=1 for 4 cycles -> sel sequence 0,1,0,1; z sequence 0,1,0,1; zv=1 from cycle 1.
REQ-034 FULL with z=1, sel=1, zr=0 for 3 cycles while v0=1 -> r0=0, z/sel/zv stable; zr=1 -> item drained and channel 0 accepted same cycle.
REQ-035 Only v1=1 for 3 consecutive items, then v0=v1=1 -> channel 0 granted (last=1).
REQ-036 rst_n low asynchronously mid-cycle while FULL -> zv=0, z=0, sel=0 immediately, before the next edge.
REQ-037 All cycles: checker asserts !(r0&&r1), z stable while zv&&!zr, in-order lossless delivery per channel against a scoreboard.

Source files
------------

// File: rtl/mux2_arb_pkg.sv
// mux2_arb_pkg: shared definitions for the two-channel arbitrating output
// register (mux2_arb).
//   state_t        : output stage occupancy (EMPTY / FULL)
//   DEFAULT_WIDTH  : default channel data width
package mux2_arb_pkg;

    // Output stage occupancy; FULL means z holds an item not yet taken.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 1;

    // Round-robin tie break: on a tie the channel not granted last wins.
    function automatic logic tie_winner(input logic last_grant);
        return ~last_grant;
    endfunction

endpackage

// File: rtl/mux2.sv
// mux2: single-bit 2:1 select.
//   d0, d1 : data inputs
//   sel    : 0 selects d0, 1 selects d1
//   z      : selected data
module mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic z
);

    assign z = sel ? d1 : d0;

endmodule

// File: rtl/mux2_arb.sv
// mux2_arb: arbitrates two valid/ready input channels onto one registered
// output stage. Ties are broken round-robin against the last granted channel;
// the output register drains and reloads in the same cycle, so a continuously
// ready sink sees one item per cycle.
//   clk, rst_n      : clock, asynchronous active-low reset
//   d0, v0, r0      : channel-0 data / valid / ready
//   d1, v1, r1      : channel-1 data / valid / ready
//   z, zv, zr       : output data (registered) / valid / ready
//   sel             : source channel of the item currently held in z
module mux2_arb
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic             v0,
    output logic             r0,
    input  logic [WIDTH-1:0] d1,
    input  logic             v1,
    output logic             r1,
    output logic [WIDTH-1:0] z,
    output logic             zv,
    input  logic             zr,
    output logic             sel
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] z_r;
    logic [WIDTH-1:0] mux_z_s;
    logic             sel_r;
    logic             last_r;
    logic             g_s;
    logic             gvalid_s;
    logic             acc_s;
    logic             r0_s;
    logic             r1_s;
    logic             in_xfer_s;

    // Per-bit data select, steered by the current grant.
    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux2 u_mux2 (
            .d0  (d0[i]),
            .d1  (d1[i]),
            .sel (g_s),
            .z   (mux_z_s[i])
        );
    end

    // Grant decode: single requester wins outright, a tie alternates.
    always_comb begin
        g_s      = 1'b0;
        gvalid_s = 1'b0;
        case ({v1, v0})
            2'b01: begin
                g_s      = 1'b0;
                gvalid_s = 1'b1;
            end
            2'b10: begin
                g_s      = 1'b1;
                gvalid_s = 1'b1;
            end
            2'b11: begin
                g_s      = tie_winner(last_r);
                gvalid_s = 1'b1;
            end
            default: begin
                g_s      = 1'b0;
                gvalid_s = 1'b0;
            end
        endcase
    end

    // Ready generation: the stage accepts when empty or draining this cycle;
    // rst_n gates ready so nothing is taken while reset is held.
    always_comb begin
        acc_s = (state_r == EMPTY) || zr;
        if (rst_n && acc_s && gvalid_s) begin
            r0_s = v0 && (g_s == 1'b0);
            r1_s = v1 && (g_s == 1'b1);
        end else begin
            r0_s = 1'b0;
            r1_s = 1'b0;
        end
        in_xfer_s = r0_s || r1_s;
    end

    // Next-state logic for the output stage occupancy.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY: begin
                if (in_xfer_s) begin
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            FULL: begin
                if (in_xfer_s) begin
                    state_nxt_s = FULL;
                end else if (zr) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // Output register: state, data, source tag and tie-break history.
    // z/sel/last only move on an input transfer; a pure drain leaves them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EMPTY;
            z_r     <= {WIDTH{1'b0}};
            sel_r   <= 1'b0;
            last_r  <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            if (in_xfer_s) begin
                z_r    <= mux_z_s;
                sel_r  <= g_s;
                last_r <= g_s;
            end else begin
                z_r    <= z_r;
                sel_r  <= sel_r;
                last_r <= last_r;
            end
        end
    end

    assign r0  = r0_s;
    assign r1  = r1_s;
    assign z   = z_r;
    assign sel = sel_r;
    assign zv  = (state_r == FULL);

endmodule

// File: tb/tb_mux2_arb.sv
// Self-checking bench for mux2_arb: directed scenarios with hand-derived
// expectations plus a randomized run against a queue-based reference model.
module tb_mux2_arb;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] d0;
    logic         v0;
    logic         r0;
    logic [W-1:0] d1;
    logic         v1;
    logic         r1;
    logic [W-1:0] z;
    logic         zv;
    logic         zr;
    logic         sel;

    int checks;
    int errors;

    mux2_arb #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d0    (d0),
        .v0    (v0),
        .r0    (r0),
        .d1    (d1),
        .v1    (v1),
        .r1    (r1),
        .z     (z),
        .zv    (zv),
        .zr    (zr),
        .sel   (sel)
    );

    // Clock: posedges at 5, 15, ...; stimulus changes on negedges.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; zr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        v0 = 1'b1; v1 = 1'b1; d0 = 8'hA5; d1 = 8'h3C; zr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({zv, sel, z} !== {1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs: zv=%b sel=%b z=%h required zv=0 sel=0 z=00", zv, sel, z);
        end
        checks++;
        if ({r0, r1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: r0=%b r1=%b required 0 0", r0, r1);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        v0 = 1'b1; d0 = 8'h01; v1 = 1'b0; zr = 1'b1;
        #1;
        checks++;
        if ({r0, r1, zv} !== 3'b100) begin
            errors++;
            $display("FAIL single_cycle0: r0=%b r1=%b zv=%b required 1 0 0", r0, r1, zv);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({zv, z, sel} !== {1'b1, 8'h01, 1'b0}) begin
            errors++;
            $display("FAIL single_cycle1: zv=%b z=%h sel=%b required 1 01 0", zv, z, sel);
        end
        @(negedge clk);
        v0 = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (zv !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: zv=%b required 0", zv);
        end
        idle_inputs();
    endtask

    task automatic test_alternate();
        logic exp_b;
        do_reset();
        v0 = 1'b1; v1 = 1'b1; d0 = 8'h00; d1 = 8'h01; zr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_b = (i % 2) != 0;
            #1;
            checks++;
            if ({r0, r1} !== {~exp_b, exp_b}) begin
                errors++;
                $display("FAIL alt_grant[%0d]: r0=%b r1=%b required %b %b", i, r0, r1, ~exp_b, exp_b);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({zv, sel, z} !== {1'b1, exp_b, 7'd0, exp_b}) begin
                errors++;
                $display("FAIL alt_out[%0d]: zv=%b sel=%b z=%h required 1 %b %h", i, zv, sel, z, exp_b, {7'd0, exp_b});
            end
            @(negedge clk);
        end
        idle_inputs();
        zr = 1'b1;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        v1 = 1'b1; d1 = 8'h01; zr = 1'b1;
        @(negedge clk);
        v1 = 1'b0; v0 = 1'b1; d0 = 8'h5A; zr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({r0, r1, zv, sel, z} !== {1'b0, 1'b0, 1'b1, 1'b1, 8'h01}) begin
                errors++;
                $display("FAIL stall[%0d]: r0=%b r1=%b zv=%b sel=%b z=%h required 0 0 1 1 01", i, r0, r1, zv, sel, z);
            end
            @(negedge clk);
        end
        zr = 1'b1;
        #1;
        checks++;
        if (r0 !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: r0=%b required 1", r0);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({zv, sel, z} !== {1'b1, 1'b0, 8'h5A}) begin
            errors++;
            $display("FAIL stall_reload: zv=%b sel=%b z=%h required 1 0 5a", zv, sel, z);
        end
        @(negedge clk);
        idle_inputs();
        zr = 1'b1;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_fairness();
        logic [W-1:0] item;
        do_reset();
        zr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            item = W'(8'h10 + i);
            v1 = 1'b1; d1 = item;
            #1;
            checks++;
            if ({r0, r1} !== 2'b01) begin
                errors++;
                $display("FAIL fair_v1only[%0d]: r0=%b r1=%b required 0 1", i, r0, r1);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({zv, sel, z} !== {1'b1, 1'b1, item}) begin
                errors++;
                $display("FAIL fair_item[%0d]: zv=%b sel=%b z=%h required 1 1 %h", i, zv, sel, z, item);
            end
            @(negedge clk);
        end
        v0 = 1'b1; d0 = 8'h77; v1 = 1'b1; d1 = 8'h88;
        #1;
        checks++;
        if ({r0, r1} !== 2'b10) begin
            errors++;
            $display("FAIL fair_tie: r0=%b r1=%b required 1 0", r0, r1);
        end
        @(negedge clk);
        idle_inputs();
        zr = 1'b1;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        v1 = 1'b1; d1 = 8'hFF; zr = 1'b0;
        @(negedge clk);
        v1 = 1'b0;
        #1;
        checks++;
        if ({zv, sel, z} !== {1'b1, 1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL areset_setup: zv=%b sel=%b z=%h required 1 1 ff", zv, sel, z);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({zv, sel, z} !== {1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL areset_immediate: zv=%b sel=%b z=%h required 0 0 00", zv, sel, z);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
    endtask

    // Randomized traffic against a one-slot model plus per-channel scoreboard.
    task automatic test_random();
        logic         m_full;
        logic         m_sel;
        logic         m_last;
        logic [W-1:0] m_z;
        logic [W-1:0] q0[$];
        logic [W-1:0] q1[$];
        logic [W-1:0] exp_d;
        logic [31:0]  rnd;
        logic         g;
        logic         req;
        logic         in_x;
        logic         out_x;
        logic         er0;
        logic         er1;
        int           delivered;
        int           accepted;

        do_reset();
        m_full = 1'b0; m_sel = 1'b0; m_last = 1'b1; m_z = '0;
        delivered = 0; accepted = 0;
        for (int c = 0; c < 800; c++) begin
            rnd = $urandom;
            v0 = rnd[0]; v1 = rnd[1];
            zr = (rnd[3:2] != 2'b00);
            rnd = $urandom;
            d0 = rnd[W-1:0];
            d1 = rnd[W+7:8];
            #1;
            req = v0 || v1;
            if (v0 && v1) g = !m_last;
            else g = v1;
            in_x  = req && (!m_full || zr);
            er0   = in_x && !g;
            er1   = in_x && g;
            out_x = m_full && zr;

            checks++;
            if ({r0, r1} !== {er0, er1}) begin
                errors++;
                $display("FAIL rnd_ready c=%0d: r0=%b r1=%b required %b %b", c, r0, r1, er0, er1);
            end
            checks++;
            if (zv !== m_full) begin
                errors++;
                $display("FAIL rnd_zv c=%0d: zv=%b required %b", c, zv, m_full);
            end
            if (m_full) begin
                checks++;
                if ({sel, z} !== {m_sel, m_z}) begin
                    errors++;
                    $display("FAIL rnd_hold c=%0d: sel=%b z=%h required %b %h", c, sel, z, m_sel, m_z);
                end
            end
            if (out_x) begin
                if (m_sel) begin
                    exp_d = (q1.size() > 0) ? q1.pop_front() : 'x;
                end else begin
                    exp_d = (q0.size() > 0) ? q0.pop_front() : 'x;
                end
                checks++;
                if (z !== exp_d) begin
                    errors++;
                    $display("FAIL rnd_scoreboard c=%0d: z=%h from ch%0d required %h", c, z, sel, exp_d);
                end
                delivered++;
            end
            if (in_x) begin
                if (g) q1.push_back(d1);
                else q0.push_back(d0);
                m_z = g ? d1 : d0;
                m_sel = g; m_last = g; m_full = 1'b1;
                accepted++;
            end else if (out_x) begin
                m_full = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (accepted - delivered !== (m_full ? 1 : 0)) begin
            errors++;
            $display("FAIL rnd_conservation: accepted=%0d delivered=%0d required difference %0d", accepted, delivered, m_full ? 1 : 0);
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_alternate();
        test_stall();
        test_fairness();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
